// File: rtl/qspi_word_reader.sv
// qspi_word_reader: reads one little-endian 32-bit word from quad-SPI flash with command 0xEB.
// Optional QSPI_ALIGN_CHECK_EN rejects unaligned addresses with resp_err instead of touching the flash.
module qspi_word_reader #(
    parameter int DUMMY_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        qspi_ck_o,
    output logic        qspi_cs_o,
    output logic [3:0]  qspi_io_o,
    input  logic [3:0]  qspi_io_i,
    output logic        qspi_io_t
);
    localparam logic [2:0] IDLE = 3'd0, CMD = 3'd1, ADDR = 3'd2, DUMMY = 3'd3, DATA = 3'd4, DONE = 3'd5;
    localparam logic [7:0] CMD_BYTE = 8'hEB;
    logic [2:0]  state;
    logic        phase;
    logic [7:0]  cnt;
    logic [7:0]  last;
    logic [23:0] addr;
    logic [31:0] sr;
    logic        active;
    logic        state_end;
    assign last      = state == ADDR ? 8'd5 : state == DUMMY ? 8'(DUMMY_CYCLES - 1) : 8'd7;
    assign state_end = phase && cnt == last;
    assign active    = state == CMD || state == ADDR || state == DUMMY || state == DATA;
    assign req_ready  = state == IDLE;
    assign resp_valid = state == DONE;
    assign qspi_cs_o  = !active;
    assign qspi_ck_o  = active && phase;
    assign qspi_io_t  = state == CMD || state == ADDR;
    assign qspi_io_o  = state == CMD  ? {3'b110, CMD_BYTE[3'd7 - cnt[2:0]]} :
                        state == ADDR ? addr[23:20] : 4'h0;
`ifdef QSPI_ALIGN_CHECK_EN
    logic err;
    assign resp_err = err && state == DONE;
    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else if (state == IDLE && req_valid) err <= req_addr[1:0] != 2'b00;
    end
`else
    assign resp_err = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= 1'b0;
            cnt       <= 8'd0;
            addr      <= 24'd0;
            sr        <= 32'd0;
            resp_data <= 32'd0;
        end else if (state == IDLE) begin
            if (req_valid) begin
                addr <= req_addr;
`ifdef QSPI_ALIGN_CHECK_EN
                state <= req_addr[1:0] != 2'b00 ? DONE : CMD;
`else
                state <= CMD;
`endif
            end
        end else if (state == DONE) begin
            state <= IDLE;
        end else begin
            phase <= ~phase;
            if (phase) begin
                cnt <= state_end ? 8'd0 : cnt + 8'd1;
                if (state == ADDR) addr <= {addr[19:0], 4'h0};
                // Byte k of the word lands in [8k+7:8k]; within a byte the high nibble arrives first.
                if (state == DATA) sr[{cnt[2:1], ~cnt[0], 2'b00} +: 4] <= qspi_io_i;
                if (state_end) begin
                    state <= state == CMD ? ADDR : state == ADDR ? DUMMY : state == DUMMY ? DATA : DONE;
                    if (state == DATA) resp_data <= {sr[31:28], qspi_io_i, sr[23:0]};
                end
            end
        end
    end
endmodule
